aes_key_sched_ctrl: RTL

Sequencer for the pipelined AES-256 key-expansion engine in the AES-GCM datapath. It accepts a 256-bit cipher key through a valid/ready handshake and holds one pending key. Rekeying is deferred until the cipher core is idle. The block then drives the two 128-bit key-load strobes, starts the expansion and times it to completion. The cipher core may use the round-key bank only while `rk_valid` is high.

---
 rtl/aes_key_sched_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl
//
// Sequencer for the pipelined AES-256 key-expansion engine. It buffers one
// pending 256-bit cipher key and waits until the cipher core is idle before
// rekeying. It then loads the two 128-bit halves into the expander, pulses
// the expansion start and times the expansion. After that it flags the
// round-key bank as valid.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   key_in         : new cipher key ([255:128] = round key 0, [127:0] = rk 1)
//   key_in_valid   : requester offers key_in
//   key_in_ready   : pending buffer empty (transfer on valid && ready)
//   cipher_busy    : cipher core mid-block, round keys must not change
//   ke_key         : 128-bit key bus to the expander
//   ke_load0/1     : expander load strobes for round key 0 / round key 1
//   ke_enable      : one-cycle expansion start
//   rk_valid       : round-key bank complete and stable
//   rk_done        : one-cycle pulse when rk_valid rises
//   key_gen        : count of completed expansions (wraps)
//   busy           : controller is rekeying (not IDLE and not READY)
// ---------------------------------------------------------------------------
module aes_key_sched_ctrl #(
    parameter int EXP_CYCLES = 28,
    parameter int GEN_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [255:0]       key_in,
    input  logic               key_in_valid,
    output logic               key_in_ready,
    input  logic               cipher_busy,
    output logic [127:0]       ke_key,
    output logic               ke_load0,
    output logic               ke_load1,
    output logic               ke_enable,
    output logic               rk_valid,
    output logic               rk_done,
    output logic [GEN_W-1:0]   key_gen,
    output logic               busy
);

    localparam int CNT_W = (EXP_CYCLES > 1) ? $clog2(EXP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_LOAD0  = 3'd2,
        S_LOAD1  = 3'd3,
        S_START  = 3'd4,
        S_EXPAND = 3'd5,
        S_READY  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic               pend_q, pend_d;
    logic [255:0]       pend_key_q;
    logic [255:0]       load_key_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rk_done_q, rk_done_d;
    logic [GEN_W-1:0]   key_gen_q, key_gen_d;
    logic               accept;
    logic               leave_wait;

    assign key_in_ready = !pend_q;
    assign accept       = key_in_valid && !pend_q;
    assign leave_wait   = (state_q == S_WAIT) && (state_d == S_LOAD0);

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            rk_done_q <= 1'b0;
            key_gen_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            rk_done_q <= rk_done_d;
            key_gen_q <= key_gen_d;
        end
    end

    // Key data registers carry no reset; pend_q and the state decide whether
    // their contents are meaningful. The load copy lets a new key be accepted
    // into the pending buffer while the halves of the current key are loaded.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_key_q <= key_in;
        end
        if (leave_wait) begin
            load_key_q <= pend_key_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rk_done_d = 1'b0;
        key_gen_d = key_gen_q;

        case (state_q)
            S_IDLE: begin
                if (pend_q) state_d = S_WAIT;
            end
            S_READY: begin
                if (pend_q) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!cipher_busy) state_d = S_LOAD0;
            end
            S_LOAD0: state_d = S_LOAD1;
            S_LOAD1: state_d = S_START;
            S_START: begin
                cnt_d   = '0;
                state_d = S_EXPAND;
            end
            S_EXPAND: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_READY;
                    rk_done_d = 1'b1;
                    key_gen_d = key_gen_q + GEN_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Accept and WAIT->LOAD0 are mutually exclusive: an occupied buffer
        // holds ready low.
        pend_d = pend_q;
        if (accept) begin
            pend_d = 1'b1;
        end else if (leave_wait) begin
            pend_d = 1'b0;
        end
    end

    // Output decode from registered state only
    always_comb begin
        ke_key    = '0;
        ke_load0  = 1'b0;
        ke_load1  = 1'b0;
        ke_enable = 1'b0;
        rk_valid  = 1'b0;
        busy      = 1'b1;

        case (state_q)
            S_IDLE:  busy = 1'b0;
            S_READY: begin
                busy     = 1'b0;
                rk_valid = 1'b1;
            end
            S_LOAD0: begin
                ke_key   = load_key_q[255:128];
                ke_load0 = 1'b1;
            end
            S_LOAD1: begin
                ke_key   = load_key_q[127:0];
                ke_load1 = 1'b1;
            end
            S_START: ke_enable = 1'b1;
            default: ;
        endcase
    end

    assign rk_done = rk_done_q;
    assign key_gen = key_gen_q;

endmodule
